// File: rtl/vga_pattern_pkg.sv
// vga_pattern_pkg: pattern mode encodings, default 640x480@60 timing and
// the colour-bar lookup shared by the pattern generator.
package vga_pattern_pkg;

  // Pattern mode encodings driven on MODE
  localparam logic [1:0] MODE_BARS    = 2'd0;
  localparam logic [1:0] MODE_CHECKER = 2'd1;
  localparam logic [1:0] MODE_RAMP    = 2'd2;
  localparam logic [1:0] MODE_SOLID   = 2'd3;

  // Default 640x480 timing (pixels / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_WIDTH  = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_WIDTH  = 2;
  localparam int DEF_V_BACK   = 33;

  // 3-bit {R,G,B} colour for a bar: descending (white first) on even bands,
  // ascending on odd bands so alternate quarter-screen bands mirror each other.
  function automatic logic [2:0] bar_colour(input logic [2:0] bar, input logic odd_band);
    logic [2:0] c;
    if (odd_band) begin
      c = bar;
    end else begin
      c = 3'd7 - bar;
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical counters, raw active-low syncs, active
// region flag and a strobe on the last counter state of each frame.
// Line layout is front porch, sync, back porch, then the active pixels.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_WIDTH  = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_WIDTH  = 2,
  parameter int V_BACK   = 33,
  localparam int HPERIOD = H_FRONT + H_WIDTH + H_BACK + H_ACTIVE,
  localparam int VPERIOD = V_FRONT + V_WIDTH + V_BACK + V_ACTIVE,
  localparam int HW      = $clog2(HPERIOD),
  localparam int VW      = $clog2(VPERIOD)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [HW-1:0] o_hcnt,
  output logic [VW-1:0] o_vcnt,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_active,
  output logic          o_frame_end
);

  localparam int HBLANK = H_FRONT + H_WIDTH + H_BACK;
  localparam int VBLANK = V_FRONT + V_WIDTH + V_BACK;
  localparam logic [HW-1:0] H_LAST = HW'(HPERIOD - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VPERIOD - 1);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_hcnt == H_LAST);
  assign w_v_last = (r_vcnt == V_LAST);

  // Pixel and line counters; the line counter steps when the pixel counter wraps
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      if (w_v_last) begin
        r_vcnt <= '0;
      end else begin
        r_vcnt <= r_vcnt + 1'b1;
      end
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
      r_vcnt <= r_vcnt;
    end
  end

  assign o_hcnt      = r_hcnt;
  assign o_vcnt      = r_vcnt;
  assign o_hs        = !((r_hcnt >= HW'(H_FRONT)) && (r_hcnt < HW'(H_FRONT + H_WIDTH)));
  assign o_vs        = !((r_vcnt >= VW'(V_FRONT)) && (r_vcnt < VW'(V_FRONT + V_WIDTH)));
  assign o_active    = (r_hcnt >= HW'(HBLANK)) && (r_vcnt >= VW'(VBLANK));
  assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA test-pattern generator (bars, checker, grey ramp,
// solid colour) with registered sync/DE/RGB outputs.
// Optional feature macro: PATTERN_SCROLL_EN adds a per-frame horizontal scroll.
// MODE and the scroll offset only change at the frame-end counter state, so a
// frame is always drawn with a single pattern and position.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_WIDTH     = DEF_H_WIDTH,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_WIDTH     = DEF_V_WIDTH,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int COLOR_W     = 4,
  parameter int BARS        = 8,
  parameter int CELL_LOG2   = 5,
  parameter int SCROLL_STEP = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             MODE,
  input  logic [3*COLOR_W-1:0]   SOLID_RGB,
  input  logic                   SCROLL,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   DE,
  output logic                   FRAME_START
);

  localparam int HBLANK = H_FRONT + H_WIDTH + H_BACK;
  localparam int VBLANK = V_FRONT + V_WIDTH + V_BACK;
  localparam int HW     = $clog2(HBLANK + H_ACTIVE);
  localparam int VW     = $clog2(VBLANK + V_ACTIVE);
  localparam int XW     = $clog2(H_ACTIVE);
  localparam int YW     = $clog2(V_ACTIVE);
  localparam int CW     = 3 * COLOR_W;
  localparam int BAR_W  = H_ACTIVE / BARS;
  localparam int BAND_H = V_ACTIVE / 4;

  logic [HW-1:0]       w_hcnt;
  logic [VW-1:0]       w_vcnt;
  logic                w_hs;
  logic                w_vs;
  logic                w_active;
  logic                w_frame_end;

  logic [XW-1:0]       w_x;
  logic [YW-1:0]       w_y;
  logic [XW-1:0]       w_offset;
  logic [XW:0]         w_sx_sum;
  logic [XW-1:0]       w_sx;
  logic [2:0]          w_bar;
  logic                w_band_odd;
  logic [2:0]          w_bar_col;
  logic                w_cell;
  logic [XW+COLOR_W-1:0] w_ramp_num;
  logic [COLOR_W-1:0]  w_level;
  logic [CW-1:0]       w_rgb;
  logic                w_fs;

  logic [1:0]          r_mode;
  logic [CW-1:0]       r_rgb;
  logic                r_hs;
  logic                r_vs;
  logic                r_de;
  logic                r_fs;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_WIDTH  (H_WIDTH),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_WIDTH  (V_WIDTH),
    .V_BACK   (V_BACK)
  ) u_timing (
    .i_clk       (CLK),
    .i_rst       (RST),
    .o_hcnt      (w_hcnt),
    .o_vcnt      (w_vcnt),
    .o_hs        (w_hs),
    .o_vs        (w_vs),
    .o_active    (w_active),
    .o_frame_end (w_frame_end)
  );

  // Active-area coordinates; only meaningful while w_active is high
  assign w_x = XW'(w_hcnt - HW'(HBLANK));
  assign w_y = YW'(w_vcnt - VW'(VBLANK));

`ifdef PATTERN_SCROLL_EN
  logic [XW-1:0] r_offset;
  logic [XW:0]   w_offset_sum;
  logic [XW-1:0] w_offset_next;

  // Next scroll offset: advance by SCROLL_STEP, wrapping at the active width
  always_comb begin
    w_offset_sum = {1'b0, r_offset} + (XW+1)'(SCROLL_STEP);
    if (w_offset_sum >= (XW+1)'(H_ACTIVE)) begin
      w_offset_next = XW'(w_offset_sum - (XW+1)'(H_ACTIVE));
    end else begin
      w_offset_next = w_offset_sum[XW-1:0];
    end
  end

  // Scroll offset moves only at frame end, in step with the mode latch
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_offset <= '0;
    end else if (w_frame_end && SCROLL) begin
      r_offset <= w_offset_next;
    end else begin
      r_offset <= r_offset;
    end
  end

  assign w_offset = r_offset;
`else
  // Scroll compiled out: offset is constant zero, SCROLL/SCROLL_STEP fold away
  assign w_offset = {XW{SCROLL & 1'b0}} & XW'(SCROLL_STEP);
`endif

  // Scrolled column, wrapped back into 0..H_ACTIVE-1
  always_comb begin
    w_sx_sum = {1'b0, w_x} + {1'b0, w_offset};
    if (w_sx_sum >= (XW+1)'(H_ACTIVE)) begin
      w_sx = XW'(w_sx_sum - (XW+1)'(H_ACTIVE));
    end else begin
      w_sx = w_sx_sum[XW-1:0];
    end
  end

  assign w_bar      = 3'(({1'b0, w_sx}) / (XW+1)'(BAR_W));
  assign w_band_odd = 1'(({1'b0, w_y}) / (YW+1)'(BAND_H));
  assign w_bar_col  = bar_colour(w_bar, w_band_odd);
  assign w_cell     = w_sx[CELL_LOG2] ^ w_y[CELL_LOG2];
  assign w_ramp_num = {w_sx, {COLOR_W{1'b0}}};
  assign w_level    = COLOR_W'(w_ramp_num / (XW+COLOR_W)'(H_ACTIVE));
  assign w_fs       = w_active && (w_x == '0) && (w_y == '0);

  // Pattern colour for the current counter position; black outside the active area
  always_comb begin
    w_rgb = '0;
    if (w_active) begin
      case (r_mode)
        MODE_BARS:    w_rgb = {{COLOR_W{w_bar_col[2]}}, {COLOR_W{w_bar_col[1]}},
                               {COLOR_W{w_bar_col[0]}}};
        MODE_CHECKER: w_rgb = {CW{w_cell}};
        MODE_RAMP:    w_rgb = {w_level, w_level, w_level};
        MODE_SOLID:   w_rgb = SOLID_RGB;
        default:      w_rgb = '0;
      endcase
    end else begin
      w_rgb = '0;
    end
  end

  // Pattern mode is latched only on the last counter state so frames never tear
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mode <= MODE_BARS;
    end else if (w_frame_end) begin
      r_mode <= MODE;
    end else begin
      r_mode <= r_mode;
    end
  end

  // Output register: one cycle from counter state to pins, all outputs aligned
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_de  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_de  <= w_active;
      r_fs  <= w_fs;
    end
  end

  assign VGA_R       = r_rgb[3*COLOR_W-1:2*COLOR_W];
  assign VGA_G       = r_rgb[2*COLOR_W-1:COLOR_W];
  assign VGA_B       = r_rgb[COLOR_W-1:0];
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign DE          = r_de;
  assign FRAME_START = r_fs;

endmodule
